// File: rtl/ads_sample_ram_writer.sv
// Avalon-MM write master that streams ADS1299 samples into a circular region of on-chip RAM.
// Define ADS_SAMPLE_TAG_EN to store the channel index with each sample instead of sign-extending.
module ads_sample_ram_writer #(
  parameter int unsigned BASE_WORD   = 0,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned BLOCK_WORDS = 256,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        s_valid,
  input  logic [23:0] s_data,
  input  logic [2:0]  s_chan,
  output logic [14:0] avm_address,
  output logic [3:0]  avm_byteenable,
  output logic        avm_chipselect,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  output logic [14:0] wr_ptr,
  output logic        block_done,
  output logic [15:0] wrap_count,
  output logic        overflow,
  input  logic        clear_ovf
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned BlkW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [14:0] BaseAddr = 15'(BASE_WORD);
  localparam logic [14:0] LastAddr = 15'(BASE_WORD + DEPTH_WORDS - 1);
  localparam logic [BlkW-1:0] BlkLast = BlkW'(BLOCK_WORDS - 1);

`ifdef ADS_SAMPLE_TAG_EN
  localparam int unsigned FifoW = 27;

  logic [FifoW-1:0] s_entry;
  assign s_entry = {s_chan, s_data};

  function automatic logic [31:0] fmt_word(input logic [FifoW-1:0] e);
    return {5'b0, e};
  endfunction
`else
  localparam int unsigned FifoW = 24;

  logic [FifoW-1:0] s_entry;
  logic             unused_chan;
  assign s_entry     = s_data;
  assign unused_chan = ^s_chan;

  function automatic logic [31:0] fmt_word(input logic [FifoW-1:0] e);
    return {{8{e[23]}}, e};
  endfunction
`endif

  typedef enum logic [1:0] {StIdle, StArm, StWrite} state_e;

  state_e state_q, state_d;

  logic [FifoW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             fifo_full, fifo_empty;

  logic [14:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [14:0]      wr_ptr_q, wr_ptr_d, ptr_inc;
  logic [15:0]      wrap_q, wrap_d;
  logic [BlkW-1:0]  blk_q, blk_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic accept, push, drop, flush, draining, at_last;
  logic load_head, load_next;

  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  assign accept   = (state_q == StWrite) && !avm_waitrequest;
  assign flush    = (state_q == StIdle) && enable;
  // Samples arriving after enable falls, while queued data is still going out, are lost.
  assign draining = !enable && (state_q != StIdle);
  assign push     = s_valid && enable && (!fifo_full || accept);
  assign drop     = s_valid && ((enable && fifo_full && !accept) || draining);

  assign at_last = (wr_ptr_q == LastAddr);
  assign ptr_inc = at_last ? BaseAddr : wr_ptr_q + 15'd1;

  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
    load_next = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StArm;
      end
      StArm: begin
        if (!fifo_empty) begin
          state_d   = StWrite;
          load_head = 1'b1;
        end else if (!enable) begin
          state_d = StIdle;
        end
      end
      StWrite: begin
        // The entry on the bus still occupies the FIFO head, so two entries are needed
        // to chain straight into the next write.
        if (accept) begin
          if (enable && (count_q >= CntW'(2))) load_next = 1'b1;
          else                                 state_d   = StArm;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rptr_d   = rptr_q + PtrW'(accept);
    wptr_d   = wptr_q + PtrW'(push);
    count_d  = count_q + CntW'(push) - CntW'(accept);
    addr_d   = addr_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    wrap_d   = wrap_q;
    blk_d    = blk_q;
    done_d   = 1'b0;
    ovf_d    = clear_ovf ? 1'b0 : (ovf_q | drop);

    if (flush) begin
      rptr_d   = wptr_q;
      count_d  = CntW'(push);
      wr_ptr_d = BaseAddr;
      wrap_d   = '0;
      blk_d    = '0;
    end

    if (accept) begin
      wr_ptr_d = ptr_inc;
      if (at_last) wrap_d = wrap_q + 16'd1;
      blk_d  = (blk_q == BlkLast) ? '0 : blk_q + BlkW'(1);
      done_d = (blk_q == BlkLast);
    end

    if (load_head) begin
      addr_d = wr_ptr_q;
      data_d = fmt_word(mem_q[rptr_q]);
    end else if (load_next) begin
      addr_d = ptr_inc;
      data_d = fmt_word(mem_q[rptr_q + PtrW'(1)]);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= s_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      rptr_q   <= '0;
      wptr_q   <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_ptr_q <= BaseAddr;
      wrap_q   <= '0;
      blk_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      wrap_q   <= wrap_d;
      blk_q    <= blk_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign avm_write      = (state_q == StWrite);
  assign avm_chipselect = (state_q == StWrite);
  assign avm_byteenable = 4'hF;
  assign avm_address    = addr_q;
  assign avm_writedata  = data_q;
  assign wr_ptr         = wr_ptr_q;
  assign wrap_count     = wrap_q;
  assign block_done     = done_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_ads_sample_ram_writer.sv
// Self-checking bench for ads_sample_ram_writer: directed steps plus randomized sample
// bursts, scored against a queue-based model of the expected RAM writes.
module tb_ads_sample_ram_writer;

  localparam int unsigned BASE  = 0;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned BLOCK = 4;
  localparam int unsigned FDEP  = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        s_valid;
  logic [23:0] s_data;
  logic [2:0]  s_chan;
  logic [14:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_chipselect;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [14:0] wr_ptr;
  logic        block_done;
  logic [15:0] wrap_count;
  logic        overflow;
  logic        clear_ovf;

  ads_sample_ram_writer #(
    .BASE_WORD  (BASE),
    .DEPTH_WORDS(DEPTH),
    .BLOCK_WORDS(BLOCK),
    .FIFO_DEPTH (FDEP)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_chan         (s_chan),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_waitrequest(avm_waitrequest),
    .wr_ptr         (wr_ptr),
    .block_done     (block_done),
    .wrap_count     (wrap_count),
    .overflow       (overflow),
    .clear_ovf      (clear_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] ram [0:32767];
  logic [14:0] mptr;
  logic [15:0] mwrap;
  int          accept_n;
  int          block_pulses;
  logic        exp_done;
  int          check_cnt;
  int          err_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_restart();
    mptr     = 15'(BASE);
    mwrap    = '0;
    accept_n = 0;
  endtask

  task automatic model_push(input logic [23:0] d, input logic [2:0] c);
    wr_t e;
    e.addr = mptr;
`ifdef ADS_SAMPLE_TAG_EN
    e.data = {5'b0, c, d};
`else
    begin
      logic [2:0] unused_c;
      unused_c = c;
      e.data   = {{8{d[23]}}, d};
    end
`endif
    exp_q.push_back(e);
    if (mptr == 15'(BASE + DEPTH - 1)) begin
      mptr  = 15'(BASE);
      mwrap = mwrap + 16'd1;
    end else begin
      mptr = mptr + 15'd1;
    end
  endtask

  task automatic push(input logic [23:0] d, input logic [2:0] c, input bit acc);
    s_valid = 1'b1;
    s_data  = d;
    s_chan  = c;
    if (acc) model_push(d, c);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    avm_waitrequest = 1'b0;
    while ((exp_q.size() != 0 || avm_write) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n < 200), 32'd1);
  endtask

  // Bus monitor: scores every write against the model and checks block_done timing.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("block_done", {31'b0, block_done}, {31'b0, exp_done});
      if (block_done) block_pulses++;
      exp_done = 1'b0;
      if (avm_write) begin
        chk("chipselect", {31'b0, avm_chipselect}, 32'd1);
        chk("byteenable", {28'b0, avm_byteenable}, 32'hF);
        check_cnt++;
        assert (exp_q.size() != 0) else begin
          err_cnt++;
          $error("FAIL unexpected_write: observed addr %0h data %0h expected no write",
                 avm_address, avm_writedata);
        end
        if (exp_q.size() != 0) begin
          chk("wr_addr", {17'b0, avm_address}, {17'b0, exp_q[0].addr});
          chk("wr_data", avm_writedata, exp_q[0].data);
          if (!avm_waitrequest) begin
            ram[avm_address] = avm_writedata;
            void'(exp_q.pop_front());
            accept_n++;
            exp_done = ((accept_n % BLOCK) == 0);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    check_cnt = 0;
    err_cnt = 0;
    block_pulses = 0;
    exp_done = 1'b0;
    model_restart();
    reset_n = 1'b0;
    enable = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    s_chan = '0;
    avm_waitrequest = 1'b0;
    clear_ovf = 1'b0;
    repeat (3) tick();

    chk("rst_write", {31'b0, avm_write}, 32'd0);
    chk("rst_cs", {31'b0, avm_chipselect}, 32'd0);
    chk("rst_be", {28'b0, avm_byteenable}, 32'hF);
    chk("rst_addr", {17'b0, avm_address}, 32'd0);
    chk("rst_data", avm_writedata, 32'd0);
    chk("rst_wr_ptr", {17'b0, wr_ptr}, BASE);
    chk("rst_wrap", {16'b0, wrap_count}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_done", {31'b0, block_done}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Five ascending samples, first one used to check the two-cycle latency.
    enable = 1'b1;
    model_restart();
    tick();
    push(24'h000001, 3'd0, 1'b1);
    @(negedge clk);
    chk("latency_n1", {31'b0, avm_write}, 32'd0);
    tick();
    @(negedge clk);
    chk("latency_n2", {31'b0, avm_write}, 32'd1);
    tick();
    for (int i = 2; i <= 5; i++) push(24'(i), 3'd0, 1'b1);
    drain();
    tick();
    chk("five_wr_ptr", {17'b0, wr_ptr}, 32'd5);
    chk("five_done", {31'b0, block_done}, 32'd0);
    chk("five_ovf", {31'b0, overflow}, 32'd0);
    chk("five_word4", ram[4], 32'h00000005);

    // Negative full-scale sample.
    push(24'h800000, 3'd3, 1'b1);
    drain();
`ifdef ADS_SAMPLE_TAG_EN
    chk("neg_fmt", ram[5], 32'h03800000);
`else
    chk("neg_fmt", ram[5], 32'hFF800000);
`endif

    // Fresh enable, 20 back-to-back samples around a 16-word ring.
    enable = 1'b0;
    repeat (3) tick();
    enable = 1'b1;
    model_restart();
    block_pulses = 0;
    tick();
    for (int i = 1; i <= 20; i++) push(24'(i), 3'd1, 1'b1);
    drain();
    repeat (2) tick();
    chk("ring_pulses", 32'(block_pulses), 32'd5);
    chk("ring_wrap", {16'b0, wrap_count}, 32'd1);
    chk("ring_wr_ptr", {17'b0, wr_ptr}, 32'd4);
    chk("ring_word0", ram[0], 32'h00000011);

    // Stalled bus: 10 samples into an 8-entry FIFO.
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 10; i++) push(24'h0A0000 + 24'(i), 3'd2, i < 8);
    repeat (2) tick();
    chk("stall_ovf", {31'b0, overflow}, 32'd1);
    clear_ovf = 1'b1;
    push(24'h0B0000, 3'd2, 1'b0);
    clear_ovf = 1'b0;
    chk("clear_priority", {31'b0, overflow}, 32'd0);
    avm_waitrequest = 1'b0;
    push(24'h0C0000, 3'd2, 1'b1);
    drain();
    chk("full_pushpop_ovf", {31'b0, overflow}, 32'd0);

    // Disable during a stalled write with three entries queued.
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) push(24'hD00000 + 24'(i), 3'd4, 1'b1);
    tick();
    enable = 1'b0;
    repeat (3) tick();
    drain();
    repeat (3) tick();
    chk("dis_idle_write", {31'b0, avm_write}, 32'd0);
    chk("dis_wr_ptr", {17'b0, wr_ptr}, {17'b0, mptr});
    chk("dis_wrap", {16'b0, wrap_count}, {16'b0, mwrap});
    enable = 1'b1;
    model_restart();
    tick();
    chk("reen_wr_ptr", {17'b0, wr_ptr}, BASE);
    chk("reen_wrap", {16'b0, wrap_count}, 32'd0);

    // Random bursts with random bus stalls; each burst fits in the FIFO.
    for (int b = 0; b < 8; b++) begin
      int n = $urandom_range(1, 7);
      int sent = 0;
      while (sent < n) begin
        avm_waitrequest = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) != 0) begin
          push(24'($urandom), 3'($urandom_range(0, 7)), 1'b1);
          sent++;
        end else begin
          tick();
        end
      end
      drain();
    end
    tick();
    chk("rand_wr_ptr", {17'b0, wr_ptr}, {17'b0, mptr});
    chk("rand_wrap", {16'b0, wrap_count}, {16'b0, mwrap});
    chk("rand_ovf", {31'b0, overflow}, 32'd0);

    // Asynchronous reset while a write is stalled on the bus.
    avm_waitrequest = 1'b1;
    push(24'h123456, 3'd5, 1'b1);
    push(24'h654321, 3'd5, 1'b1);
    begin
      int n = 0;
      while (!avm_write && n < 10) begin
        tick();
        n++;
      end
      chk("rst_wait_write", {31'b0, avm_write}, 32'd1);
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_write", {31'b0, avm_write}, 32'd0);
    chk("async_cs", {31'b0, avm_chipselect}, 32'd0);
    exp_q.delete();
    exp_done = 1'b0;
    model_restart();
    enable = 1'b0;
    avm_waitrequest = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_wr_ptr", {17'b0, wr_ptr}, BASE);
    chk("post_rst_write", {31'b0, avm_write}, 32'd0);
    enable = 1'b1;
    tick();
    push(24'h7FFFFF, 3'd6, 1'b1);
    drain();
    tick();
    chk("post_rst_one", {17'b0, wr_ptr}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ads_sample_ram_writer.md
Name: ads_sample_ram_writer

Overview:
- Avalon-MM write master that streams 24-bit ADS1299 samples into the 32-bit single-port on-chip RAM slave (15-bit word address, byte enables, chipselect/write).
- Acts as a circular capture buffer between the ADS1299 SPI front-end and the Nios-visible sample memory.
- Buffers incoming samples in a small FIFO and issues one 32-bit write per sample.
- Raises a block-done pulse so software can process SSVEP epochs while capture continues.

Parameters:
- BASE_WORD, 0, first word address of the ring inside the RAM.
- DEPTH_WORDS, 4096, ring length in 32-bit words; BASE_WORD+DEPTH_WORDS ≤ 32768.
- BLOCK_WORDS, 256, words per block_done pulse; must divide DEPTH_WORDS.
- FIFO_DEPTH, 8, input FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  level; 1 = capture running
- s_valid  in  1  sample valid from front-end; the front-end cannot stall
- s_data  in  24  two's-complement sample
- s_chan  in  3  ADS1299 channel index
- avm_address  out  15  word address to RAM
- avm_byteenable  out  4  byte enables; always 4'hF during a write
- avm_chipselect  out  1  asserted with avm_write
- avm_write  out  1  write request
- avm_writedata  out  32  write data
- avm_waitrequest  in  1  interconnect stall; tie 0 for a direct RAM connection
- wr_ptr  out  15  next word address to be written
- block_done  out  1  one-cycle pulse per completed block
- wrap_count  out  16  ring wraps since enable rose; wraps modulo 2^16
- overflow  out  1  sticky sample-dropped flag
- clear_ovf  in  1  synchronous clear for overflow

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, FIFO empty, wr_ptr=BASE_WORD.
  - All Avalon outputs 0, except avm_byteenable=4'hF.
  - block_done=0, wrap_count=0, overflow=0.
- FIFO:
  - Push when s_valid & enable & !full.
  - s_valid & full (or s_valid while a disable drain is in progress) drops the sample and sets overflow.
  - Simultaneous push and pop when full is legal: the pop frees a slot, the push is accepted, no overflow.
  - clear_ovf has priority over a same-cycle set.
- Data formatting: avm_writedata = {{8{s_data[23]}}, s_data} (sign extension).
- FSM:
  - IDLE: wr_ptr held. On enable rising edge: wr_ptr←BASE_WORD, wrap_count←0, block counter←0, FIFO flushed. Go to ARM.
  - ARM: if enable=0, go to IDLE. If FIFO not empty, load the head into the output registers, assert avm_write/avm_chipselect next cycle, go to WRITE.
  - WRITE: hold address and data stable while avm_waitrequest=1. On the cycle avm_write=1 & avm_waitrequest=0, the write is accepted:
    - Pop the FIFO.
    - Advance wr_ptr: wrap to BASE_WORD after BASE_WORD+DEPTH_WORDS-1, and increment wrap_count on wrap.
    - Advance the block counter.
    - Go to ARM, or go back-to-back: if the FIFO holds another entry and enable=1, stay in WRITE with the next entry loaded (one write per cycle sustained).
- block_done: pulses the cycle after the accept that completes a multiple of BLOCK_WORDS.
- Latency: a sample pushed into an empty FIFO in cycle N appears on the bus with avm_write=1 in cycle N+2 when waitrequest=0.
- Disable mid-operation:
  - A write already on the bus completes (Avalon hold rule).
  - Remaining FIFO contents are still written.
  - Return to IDLE once the FIFO is empty.
  - wr_ptr, wrap_count and overflow are held until the next enable rise.
- Only write transfers are issued; read, burst and response signals are absent.

Optional Feature:
- Macro ADS_SAMPLE_TAG_EN.
  - Defined: avm_writedata = {5'b0, s_chan, s_data}, so the channel tag is stored with each sample; FIFO width is 27 bits.
  - Undefined: sign-extended format as above; s_chan is ignored and FIFO width is 24 bits.

Test Plan:
- Enable, 5 samples 24'h000001..24'h000005, waitrequest=0 → writes to words 0..4 with data 32'h00000001..5. Then wr_ptr=5, block_done=0, overflow=0.
- Sample 24'h800000 → writedata 32'hFF800000 (tag undefined); with ADS_SAMPLE_TAG_EN and s_chan=3 → 32'h03800000.
- DEPTH_WORDS=16, BLOCK_WORDS=4, 20 samples:
  - block_done pulses after accepts 4, 8, 12, 16, 20.
  - wrap_count=1, wr_ptr=4.
  - Word 0 holds sample 17.
- Hold waitrequest=1 for 12 cycles while s_valid pulses 10 times, FIFO_DEPTH=8 → 8 accepted, 2 dropped, overflow=1. Address/data stable during the stall. Asserting clear_ovf → overflow=0.
- Drop enable during a stalled write with 3 entries queued → all 3 written after the stall, then IDLE. Re-enable → wr_ptr=BASE_WORD, wrap_count=0.
- Assert reset_n=0 mid-write → avm_write/avm_chipselect=0 immediately (async). After release: IDLE, FIFO empty.
